// File: rtl/online_ccm_serial.sv
// Digit-serial MSD-first online multiplier by C = 2^SHIFT +/- 1 on borrow-save digits.
// Sums x*2^SHIFT and +/-x through a radix-2 signed-digit online adder (online delay 2).
module online_ccm_serial #(
  parameter int unsigned N_DIG   = 4,
  parameter int unsigned SHIFT   = 6,
  parameter int unsigned SGN_NEG = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_first,
  input  logic [1:0] in_digit,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_first,
  output logic       out_last,
  output logic [1:0] out_digit,
  output logic       busy
);

  localparam int unsigned STEPS = N_DIG + SHIFT + 2;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         dly_q [SHIFT];
  logic [1:0]         dly_d [SHIFT];
  logic signed [2:0]  sp_q, sp_d;
  logic signed [1:0]  wp_q, wp_d;
  logic               out_valid_q, out_valid_d;
  logic               out_first_q, out_first_d;
  logic               out_last_q, out_last_d;
  logic [1:0]         out_digit_q, out_digit_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic               step_c;
  logic [CNT_W-1:0]   cnt_n_c;
  logic [1:0]         a_dig_c, b_dig_c;
  logic signed [2:0]  s_c, z_c;
  logic signed [1:0]  t_c, w_c;

  function automatic logic signed [2:0] dval(input logic [1:0] d);
    return (d == 2'b10) ? 3'sd1 : ((d == 2'b01) ? -3'sd1 : 3'sd0);
  endfunction

  function automatic logic [1:0] denc(input logic signed [2:0] v);
    return (v == 3'sd1) ? 2'b10 : ((v == -3'sd1) ? 2'b01 : 2'b00);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    sp_d        = sp_q;
    wp_d        = wp_q;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    out_digit_d = 2'b00;
    step_c      = 1'b0;
    a_dig_c     = 2'b00;
    t_c         = 2'sd0;
    w_c         = 2'sd0;

    unique case (state_q)
      IDLE:    begin step_c = in_valid & in_first; a_dig_c = in_digit; end
      LOAD:    begin step_c = in_valid;            a_dig_c = in_digit; end
      default: step_c = 1'b1;
    endcase

    // B operand is the delayed x stream, negated for C = 2^S - 1
    b_dig_c = (SGN_NEG != 0) ? {dly_q[SHIFT-1][0], dly_q[SHIFT-1][1]} : dly_q[SHIFT-1];
    s_c     = dval(a_dig_c) + dval(b_dig_c);

    // Split previous position sum into transfer/interim using the new sum as lookahead
    if (sp_q == 3'sd2) begin
      t_c = 2'sd1;
    end else if (sp_q == -3'sd2) begin
      t_c = -2'sd1;
    end else if (sp_q == 3'sd1) begin
      if (s_c >= 3'sd0) begin t_c = 2'sd1;  w_c = -2'sd1; end
      else              begin t_c = 2'sd0;  w_c = 2'sd1;  end
    end else if (sp_q == -3'sd1) begin
      if (s_c >= 3'sd0) begin t_c = 2'sd0;  w_c = -2'sd1; end
      else              begin t_c = -2'sd1; w_c = 2'sd1;  end
    end
    z_c     = 3'(wp_q) + 3'(t_c);
    cnt_n_c = cnt_q + CNT_W'(1);

    if (step_c) begin
      dly_d[0] = a_dig_c;
      for (int unsigned i = 1; i < SHIFT; i++) dly_d[i] = dly_q[i-1];
      sp_d        = s_c;
      wp_d        = w_c;
      out_valid_d = (cnt_q != '0);
      out_first_d = (cnt_q == CNT_W'(1));
      out_last_d  = (cnt_q == CNT_W'(STEPS - 1));
      out_digit_d = (cnt_q == CNT_W'(1)) ? denc(3'(t_c)) : denc(z_c);
      if (cnt_n_c < CNT_W'(N_DIG)) begin
        state_d = LOAD;
        cnt_d   = cnt_n_c;
      end else if (cnt_n_c < CNT_W'(N_DIG + SHIFT)) begin
        state_d = PAD;
        cnt_d   = cnt_n_c;
      end else if (cnt_n_c < CNT_W'(STEPS)) begin
        state_d = FLUSH;
        cnt_d   = cnt_n_c;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < SHIFT; i++) dly_q[i] <= 2'b00;
      sp_q        <= 3'sd0;
      wp_q        <= 2'sd0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_digit_q <= 2'b00;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      sp_q        <= sp_d;
      wp_q        <= wp_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_digit_q <= out_digit_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_digit = out_digit_q;
  assign busy      = busy_q;

endmodule

// File: doc/online_ccm_serial.md
Name: online_ccm_serial

Overview:
- Digit-serial, MSD-first online constant-coefficient multiplier.
- Computes y = x * (2^SHIFT + SGN), with SGN = +1 or -1, on borrow-save radix-2 signed-digit streams.
- Generalises the parallel fixed-constant online CCMs: parametrised digit count, shift and sign.
- Sequential framing: input handshake and stall support, output stream with first/last markers.
- Sits between digit-serial online operators in the filter datapath.

Parameters:
- N_DIG, 4: digits per input operand.
- SHIFT, 6: constant shift S, range 1..16.
- SGN_NEG, 0: 0 gives C = 2^S + 1; 1 gives C = 2^S - 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_digit is valid this cycle.
- in_first  in  1  marks the first (MS) digit of a frame.
- in_digit  in  2  borrow-save digit {p,n}, value p-n; {1,1} is treated as 0.
- in_ready  out  1  block accepts a digit this cycle.
- out_valid  out  1  out_digit is valid.
- out_first  out  1  first (MS) output digit of the frame.
- out_last  out  1  last (LS) output digit of the frame.
- out_digit  out  2  borrow-save output digit {p,n}.
- busy  out  1  frame in progress (any state other than IDLE).

Behaviour:
- Operand value: x = sum over i of d_i*2^(N_DIG-1-i), with i=0 the MSD. Output is N_DIG+SHIFT+1 digits whose value equals x*C exactly. Representation is redundant; only the value is normative.
- Internal operand A = x digits followed by S zero digits (x*2^S).
- Internal operand B = S zero digits followed by x digits. B is negated (p/n swapped) when SGN_NEG=1. x digits come from an S-deep digit delay line.
- A and B feed a serial borrow-save online adder with online delay 2. Output digit k needs operand steps 0..k+1.
- FSM states:
  - IDLE: in_ready=1. A digit with in_valid&in_first is step 0, go to LOAD. Valid digits without in_first are dropped.
  - LOAD: in_ready=1. Each in_valid cycle is one step. A cycle without in_valid is a stall: no step, pipeline frozen, out_valid=0. in_first is ignored. After step N_DIG-1, go to PAD.
  - PAD: in_ready=0. S steps with zero input digit, one per cycle, no stalls. Then go to FLUSH.
  - FLUSH: in_ready=0. 2 steps feeding zero into both operands. Then go to IDLE.
- Total steps per frame: N_DIG+SHIFT+2.
- Output digit k (k=0..N_DIG+SHIFT) is registered and presented in the cycle after step k+1.
  - out_first marks k=0; out_last marks k=N_DIG+SHIFT.
  - Without stalls, out_first appears 2 cycles after step 0 is accepted.
  - A stall before step k+1 delays digit k one cycle per stalled cycle.
- A new frame can start in the cycle IDLE is re-entered. The last output digit may be presented in that same cycle.
- out_first and out_last coincide only if N_DIG+SHIFT=0, which is illegal.
- Reset values: state IDLE, delay line and adder state zero, out_valid=0, out_first=0, out_last=0, out_digit=2'b00, busy=0. in_ready=1 in the first cycle after reset.
- rst mid-frame aborts the frame. No further out_valid until a new frame completes step 1.
- No output back-pressure; the consumer must accept every out_valid digit.

Test Plan:
- N=4, S=6, SGN_NEG=0; x digits (+1,0,0,0)=8, no stalls -> 11 digits, value 520; out_first 2 cycles after step 0; out_last 10 cycles after out_first.
- Same config, x=(-1,-1,-1,-1)=-15 -> value -975; then x=(+1,+1,+1,+1)=15 -> value 975; check full range without overflow.
- SGN_NEG=1, x=(0,+1,0,+1)=5 -> value 315 (5*63); x=(+1,-1,0,0)=4 -> value 252.
- Stall: x=8 with in_valid low for 3 cycles between digits 1 and 2 -> value 520; out_valid gaps match the stalls; in_ready stays high through the stalls.
- Back-to-back frames x=3 then x=-7, second in_first presented on the first in_ready cycle -> values 195 and -455; correct first/last markers; no lost or extra digits.
- rst asserted during PAD -> next cycle out_valid=0, busy=0, in_ready=1; subsequent frame x=1 -> value 65. Also: in_digit {1,1} inside a frame is treated as 0.
